// File: rtl/qea_host_sequencer.sv
// Host-side initiator for QEA: streams context words in, seeds the state RAM with |0..0>,
// starts the core, waits for completion, then streams every state row back out.
module qea_hs_lane #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  always_ff @(posedge clk) begin
    if (!rst_n)   dout <= '0;
    else if (cap) dout <= din;
  end
endmodule

module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = DATA_WIDTH*2,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH*2,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int READ_LATENCY            = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_start,
  input  logic                                 i_complete,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic [STATE_ADDR_WIDTH-1:0]          o_rd_addr,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err
);
  localparam int ROW_W = PE_NUM*STATE_DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE_FX = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << NUM_FRAC_BIT;
  // |0..0>: amplitude 1.0+0i in the most significant lane, everything else zero
  localparam logic [ROW_W-1:0] INIT_ROW = {ONE_FX, {(ROW_W-DATA_WIDTH){1'b0}}};
  localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] INS_ONE = 1;
  localparam logic [STATE_ADDR_WIDTH:0] ROWS_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_START, S_WAIT_CMP,
    S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE
  } state_t;

  state_t                            state;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]  ctx_cnt, ins_last;
  logic [STATE_ADDR_WIDTH-1:0]       row, last_row;
  logic                              first_wait;
  logic [READ_LATENCY:0]             vld_pipe;

  logic [MAX_QBIT_WIDTH-1:0]         shift;
  logic [STATE_ADDR_WIDTH:0]         rows_full;
  logic [STATE_ADDR_WIDTH-1:0]       rows_m1;
  logic                              run_bad, rd_cap;

  assign shift     = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign rows_full = ROWS_ONE << shift;
  assign rows_m1   = STATE_ADDR_WIDTH'(rows_full - ROWS_ONE);
  assign run_bad   = (i_ins_num == '0)
                  || (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
                  || (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH));
  // read data is valid READ_LATENCY cycles after the enable reaches the RAM pins
  assign rd_cap    = (state == S_RD_WAIT) && vld_pipe[READ_LATENCY];

  logic [PE_NUM-1:0][STATE_DATA_WIDTH-1:0] dout_lanes, rd_lanes;
  assign dout_lanes = i_state_dout;
  assign o_rd_data  = rd_lanes;

  for (genvar g = 0; g < PE_NUM; g++) begin : g_lane
    qea_hs_lane #(.W(STATE_DATA_WIDTH)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .cap  (rd_cap),
      .din  (dout_lanes[g]),
      .dout (rd_lanes[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ctx_cnt       <= '0;
      ins_last      <= '0;
      row           <= '0;
      last_row      <= '0;
      first_wait    <= 1'b0;
      vld_pipe      <= '0;
      o_ctx_ready   <= 1'b0;
      o_ctx_en      <= 1'b0;
      o_ctx_wea     <= 1'b0;
      o_ctx_addr    <= '0;
      o_ctx_data    <= '0;
      o_state_ena   <= 1'b0;
      o_state_wea   <= 1'b0;
      o_state_addra <= '0;
      o_state_dina  <= '0;
      o_start       <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_addr     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_ctx_en    <= 1'b0;
      o_ctx_wea   <= 1'b0;
      o_state_ena <= 1'b0;
      o_state_wea <= 1'b0;
      o_start     <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      vld_pipe    <= {vld_pipe[READ_LATENCY-1:0], state == S_RD_ISSUE};
      case (state)
        S_IDLE: if (i_run) begin
          if (run_bad) o_err <= 1'b1;
          else begin
            ins_last    <= i_ins_num - INS_ONE;
            last_row    <= rows_m1;
            ctx_cnt     <= '0;
            o_ctx_ready <= 1'b1;
            o_busy      <= 1'b1;
            state       <= S_LOAD_CTX;
          end
        end
        S_LOAD_CTX: if (i_ctx_valid && o_ctx_ready) begin
          o_ctx_en   <= 1'b1;
          o_ctx_wea  <= 1'b1;
          o_ctx_addr <= ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
          o_ctx_data <= i_ctx_data;
          ctx_cnt    <= ctx_cnt + INS_ONE;
          if (ctx_cnt == ins_last) begin
            o_ctx_ready <= 1'b0;
            row         <= '0;
            state       <= S_INIT_STATE;
          end
        end
        S_INIT_STATE: begin
          o_state_ena   <= 1'b1;
          o_state_wea   <= 1'b1;
          o_state_addra <= row;
          o_state_dina  <= (row == '0) ? INIT_ROW : '0;
          row           <= row + STATE_ADDR_WIDTH'(1);
          if (row == last_row) state <= S_START;
        end
        S_START: begin
          o_start    <= 1'b1;
          first_wait <= 1'b1;
          state      <= S_WAIT_CMP;
        end
        // complete may still be high from the previous run on the first cycle
        S_WAIT_CMP: begin
          first_wait <= 1'b0;
          if (!first_wait && i_complete) begin
            row   <= '0;
            state <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          o_state_ena   <= 1'b1;
          o_state_addra <= row;
          state         <= S_RD_WAIT;
        end
        S_RD_WAIT: if (vld_pipe[READ_LATENCY]) begin
          o_rd_valid <= 1'b1;
          o_rd_addr  <= row;
          state      <= S_RD_OUT;
        end
        S_RD_OUT: if (i_rd_ready) begin
          o_rd_valid <= 1'b0;
          if (row == last_row) state <= S_DONE;
          else begin
            row   <= row + STATE_ADDR_WIDTH'(1);
            state <= S_RD_ISSUE;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
